// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences one CPU load/store at a time onto a 512-byte RAM port.
//   Requests are checked before the RAM is touched. A misaligned access or an
//   illegal size gives error code 01, an address outside the RAM gives code 10,
//   and a RAM that never answers gives code 11. Load data is formatted and
//   held in rdata until the next load completes.
//
//   state  | meaning
//   IDLE   | waiting for req; the request is checked and latched here
//   ACCESS | RAM enabled with the latched request; waiting for ram_finished
//   DONE   | one-cycle done pulse
//   ERR    | one-cycle err pulse with err_code
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req, wr, addr,    CPU request (sampled in IDLE only)
//   wdata, size,
//   sign_ext
//   ram_out,          RAM read data and completion
//   ram_finished
//   ram_en, ram_rw,   RAM command (ram_rw: 1 = read)
//   ram_adr, ram_data,
//   ram_size, ram_place
//   rdata             formatted load result
//   done, err,        completion / error pulses, error code
//   err_code
//   busy              high whenever not IDLE
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] ram_out,
  input  logic        ram_finished,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [8:0]  ram_adr,
  output logic [31:0] ram_data,
  output logic [1:0]  ram_size,
  output logic [1:0]  ram_place,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int CW = ($clog2(TIMEOUT) < 4) ? 4 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic          wr_q;
  logic [8:0]    addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          sext_q;
  logic [1:0]    code_q;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;

  logic bad_align;
  logic bad_range;
  logic timed_out;

  // Request checks are made on the live inputs so that the decision is ready
  // at the same edge that latches the request.
  assign bad_align = (size == 2'b11) ||
                     (size == 2'b01 && addr[0]) ||
                     (size == 2'b10 && addr[1:0] != 2'b00);
  assign bad_range = |addr[31:9];
  assign timed_out = !ram_finished && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req) state_nxt = (bad_align || bad_range) ? S_ERR : S_ACCESS;
      S_ACCESS: begin
        if (ram_finished)   state_nxt = S_DONE;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_DONE:   state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  function automatic logic [31:0] fmt_load(input logic [31:0] d,
                                           input logic [1:0]  sz,
                                           input logic        sx);
    case (sz)
      2'b00:   fmt_load = {{24{sx & d[7]}}, d[7:0]};
      2'b01:   fmt_load = {{16{sx & d[15]}}, d[15:0]};
      default: fmt_load = d;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      code_q  <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      if (state == S_IDLE && req) begin
        wr_q    <= wr;
        addr_q  <= addr[8:0];
        wdata_q <= wdata;
        size_q  <= size;
        sext_q  <= sign_ext;
        // Alignment/size errors win over range errors.
        code_q  <= bad_align ? 2'b01 : (bad_range ? 2'b10 : 2'b00);
      end
      if (state == S_ACCESS) begin
        cnt <= cnt + CW'(1);
        if (ram_finished && !wr_q) rdata_q <= fmt_load(ram_out, size_q, sext_q);
        if (timed_out)             code_q  <= 2'b11;
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    ram_en   = 1'b0;
    ram_rw   = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    err_code = 2'b00;
    busy     = 1'b1;
    case (state)
      S_IDLE:   busy = 1'b0;
      S_ACCESS: begin
        ram_en = 1'b1;
        ram_rw = ~wr_q;
      end
      S_DONE:   done = 1'b1;
      S_ERR: begin
        err      = 1'b1;
        err_code = code_q;
      end
      default:  busy = 1'b1;
    endcase
  end

  assign ram_adr   = addr_q;
  assign ram_data  = wdata_q;
  assign ram_size  = size_q;
  assign ram_place = addr_q[1:0];
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] ram_out;
  logic        ram_finished;
  logic        ram_en;
  logic        ram_rw;
  logic [8:0]  ram_adr;
  logic [31:0] ram_data;
  logic [1:0]  ram_size;
  logic [1:0]  ram_place;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .size(size), .sign_ext(sign_ext), .ram_out(ram_out), .ram_finished(ram_finished),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_adr(ram_adr), .ram_data(ram_data),
    .ram_size(ram_size), .ram_place(ram_place), .rdata(rdata), .done(done),
    .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rdata_mdl = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load result as the CPU sees it: take the low 8/16/32 bits as an unsigned
  // number, and for a signed load subtract 2^n when the value is negative.
  function automatic logic [31:0] load_model(input logic [31:0] r, input logic [1:0] sz,
                                             input logic sx);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = r % 32'd256;
        if (sx && v >= 32'd128) v = v - 32'd256;
      end
      2'd1: begin
        v = r % 32'd65536;
        if (sx && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = r;
    endcase
    return v;
  endfunction

  task automatic scramble(input logic hold_req);
    req      = hold_req ? 1'b1 : 1'($urandom);
    wr       = 1'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
    size     = 2'($urandom);
    sign_ext = 1'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ram_en"},   32'(ram_en),    32'd0);
    chk({tag, "_ram_rw"},   32'(ram_rw),    32'd1);
    chk({tag, "_ram_adr"},  32'(ram_adr),   32'd0);
    chk({tag, "_ram_data"}, ram_data,       32'd0);
    chk({tag, "_ram_size"}, 32'(ram_size),  32'd0);
    chk({tag, "_ram_place"},32'(ram_place), 32'd0);
    chk({tag, "_rdata"},    rdata,          32'd0);
    chk({tag, "_done"},     32'(done),      32'd0);
    chk({tag, "_err"},      32'(err),       32'd0);
    chk({tag, "_err_code"}, 32'(err_code),  32'd0);
    chk({tag, "_busy"},     32'(busy),      32'd0);
  endtask

  // One transaction, starting from an IDLE cycle. lat = ACCESS cycle index
  // (from 0) on which ram_finished is driven; lat >= TO means never.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic sx, input int lat,
                         input logic [31:0] rv, input logic hold_req);
    int code;
    code = 0;
    if (sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)) code = 1;
    else if (a > 32'd511) code = 2;

    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_ram_en", 32'(ram_en), 32'd0);
    req = 1'b1; wr = w; addr = a; wdata = d; size = sz; sign_ext = sx;
    ram_out = rv; ram_finished = 1'($urandom);

    @(negedge clk);
    scramble(hold_req);
    if (code != 0) begin
      chk("req_err", 32'(err), 32'd1);
      chk("req_err_code", 32'(err_code), 32'(code));
      chk("req_err_ram_en", 32'(ram_en), 32'd0);
      chk("req_err_done", 32'(done), 32'd0);
      chk("req_err_busy", 32'(busy), 32'd1);
      chk("req_err_rdata", rdata, rdata_mdl);
      ram_finished = 1'($urandom);
    end else begin
      for (int k = 0; k < TO; k++) begin
        if (k > 0) begin
          @(negedge clk);
          scramble(hold_req);
        end
        chk("acc_ram_en", 32'(ram_en), 32'd1);
        chk("acc_ram_rw", 32'(ram_rw), 32'(!w));
        chk("acc_ram_adr", 32'(ram_adr), a % 32'd512);
        chk("acc_ram_data", ram_data, d);
        chk("acc_ram_size", 32'(ram_size), 32'(sz));
        chk("acc_ram_place", 32'(ram_place), a % 32'd4);
        chk("acc_done", 32'(done), 32'd0);
        chk("acc_err", 32'(err), 32'd0);
        chk("acc_busy", 32'(busy), 32'd1);
        ram_out = rv;
        ram_finished = (k == lat);
        if (k == lat) break;
      end
      @(negedge clk);
      if (lat < TO) begin
        if (!w) rdata_mdl = load_model(rv, sz, sx);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_err", 32'(err), 32'd0);
      end else begin
        chk("to_err", 32'(err), 32'd1);
        chk("to_err_code", 32'(err_code), 32'd3);
        chk("to_done", 32'(done), 32'd0);
      end
      chk("end_ram_en", 32'(ram_en), 32'd0);
      chk("end_rdata", rdata, rdata_mdl);
      ram_finished = 1'($urandom);
      ram_out = $urandom;
    end
    req = hold_req;
  endtask

  task automatic stray_finish_idle();
    @(negedge clk);
    req = 1'b0;
    ram_finished = 1'b1;
    @(negedge clk);
    chk("stray_done", 32'(done), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);
    ram_finished = 1'b0;
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 32'h40; size = 2'd2; sign_ext = 1'b0;
    ram_finished = 1'b0;
    @(negedge clk);
    req = 1'b0;
    chk("rst_acc_en", 32'(ram_en), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rdata_mdl = 32'd0;
    check_reset_vals("rst_mid");
    for (int i = 0; i < TO + 2; i++) begin
      @(negedge clk);
      chk("rst_after_done", 32'(done), 32'd0);
      chk("rst_after_err", 32'(err), 32'd0);
      chk("rst_after_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] a;
    reset = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; size = '0;
    sign_ext = 1'b0; ram_out = '0; ram_finished = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // byte loads with and without sign extension
    run_txn(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 1, 32'h0000_0080, 1'b0);
    chk("byte_sx", rdata, 32'hFFFF_FF80);
    run_txn(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 1, 32'h0000_0080, 1'b0);
    chk("byte_zx", rdata, 32'h0000_0080);
    // word store leaves rdata alone
    run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 3, $urandom, 1'b0);
    chk("store_rdata", rdata, 32'h0000_0080);
    // misaligned half, out-of-range word, both errors at once
    run_txn(1'b0, 32'h03, 32'h0, 2'd1, 1'b0, 0, 32'h0, 1'b0);
    run_txn(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 0, 32'h0, 1'b0);
    run_txn(1'b1, 32'h8000_0001, 32'h0, 2'd1, 1'b0, 0, 32'h0, 1'b0);
    // timeout, and ram_finished on the last allowed cycle
    run_txn(1'b0, 32'h44, 32'h0, 2'd2, 1'b0, TO, 32'h1234_5678, 1'b0);
    run_txn(1'b0, 32'h1FE, 32'h0, 2'd1, 1'b1, TO - 1, 32'h0000_8001, 1'b0);
    // req held through DONE, then a back-to-back request from IDLE
    run_txn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, 32'hCAFE_F00D, 1'b1);
    run_txn(1'b0, 32'h21, 32'h0, 2'd0, 1'b1, 0, 32'h0000_00FF, 1'b0);
    stray_finish_idle();
    reset_mid_access();

    for (int t = 0; t < 200; t++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 511));
      lat = $urandom_range(0, TO + 3);
      run_txn(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), lat, $urandom,
              1'($urandom));
      if ($urandom_range(0, 9) == 0) stray_finish_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles in ACCESS waiting for ram_finished.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  CPU access request, sampled only in IDLE.
REQ-006 wr  input  1  1 = store, 0 = load.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, right-justified.
REQ-009 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 sign_ext  input  1  1 = sign-extend load result, 0 = zero-extend.
REQ-011 ram_out  input  32  RAM read data, right-justified.
REQ-012 ram_finished  input  1  RAM operation complete.
REQ-013 ram_en  output  1  RAM enable.
REQ-014 ram_rw  output  1  1 = read, 0 = write (RAM polarity).
REQ-015 ram_adr  output  9  RAM address = latched addr[8:0].
REQ-016 ram_data  output  32  latched wdata.
REQ-017 ram_size  output  2  latched size.
REQ-018 ram_place  output  2  latched addr[1:0].
REQ-019 rdata  output  32  formatted load result.
REQ-020 done  output  1  one-cycle completion pulse (MOC).
REQ-021 err  output  1  one-cycle error pulse.
REQ-022 err_code  output  2  01 misaligned/illegal size, 10 out of range, 11 timeout; valid with err.
REQ-023 busy  output  1  high in every state except IDLE.

Function
REQ-024 SHALL implement states IDLE, ACCESS, DONE, ERR.
REQ-025 IDLE with req=1: latch wr, addr, wdata, size, sign_ext; go to ERR if size=11 or (size=01 and addr[0]=1) or (size=10 and addr[1:0]!=00) (code 01); else ERR if addr[31:9]!=0 (code 10); else go to ACCESS.
REQ-026 Code 01 SHALL take priority over code 10 when both apply.
REQ-027 ACCESS: ram_en=1, ram_rw=~wr, ram_* driven from latched values, constant throughout ACCESS.
REQ-028 ACCESS: 4-bit-or-wider cycle counter cleared on entry, incremented each ACCESS cycle.
REQ-029 ACCESS with ram_finished=1: capture load result into rdata (loads only), go to DONE.
REQ-030 ACCESS with ram_finished=0 and counter = TIMEOUT-1: go to ERR with code 11; ram_finished on that same cycle wins (go to DONE).
REQ-031 Load formatting: byte = ram_out[7:0], half = ram_out[15:0], word = ram_out; upper bits = sign bit if sign_ext=1 else 0; sign_ext ignored for word.
REQ-032 Stores SHALL leave rdata unchanged.
REQ-033 DONE: done=1, ram_en=0, one cycle, then IDLE; ERR: err=1, ram_en=0, one cycle, then IDLE.
REQ-034 Latency: req sampled at edge N, ACCESS during cycle N+1; ram_finished first seen at edge M gives done high during cycle M+1; minimum req-to-done 2 cycles.
REQ-035 req while busy SHALL be ignored (not queued); ram_finished outside ACCESS SHALL be ignored.
REQ-036 ram_en SHALL be 0 in IDLE, DONE, ERR; RAM never enabled for an erroring request.
REQ-037 rdata SHALL hold its value until the next completed load.

Reset
REQ-038 reset=1 at an edge: state IDLE, counter 0, rdata 0, ram_en 0, ram_rw 1, ram_adr 0, ram_data 0, ram_size 0, ram_place 0, done 0, err 0, err_code 0, busy 0.
REQ-039 reset mid-ACCESS SHALL drop ram_en at that edge and discard the transaction (no done, no err).

Verification
REQ-040 Store word wdata=0xDEADBEEF addr=0x10, ram_finished 3 cycles into ACCESS -> ram_rw=0, ram_adr=0x010, ram_size=10, done pulse, rdata unchanged.
REQ-041 Load byte addr=0x13 sign_ext=1, ram_out=0x00000080 -> ram_place=11, rdata=0xFFFFFF80; repeat sign_ext=0 -> 0x00000080.
REQ-042 Load half addr=0x03 -> err, err_code=01, ram_en never high; word addr=0x200 -> err_code=10.
REQ-043 ram_finished held 0 -> err_code=11 exactly TIMEOUT cycles after ACCESS entry, ram_en low next cycle.
REQ-044 req held high across DONE -> second transaction starts only from IDLE; stray ram_finished in IDLE -> no done.
REQ-045 reset asserted during ACCESS -> all outputs at reset values next cycle, no done/err pulse.
